// File: rtl/riscv_div_if.sv
// rtl/riscv_div_if.sv - request/response bundle between execute stage and riscv_div
interface riscv_div_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, flush_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, flush_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/riscv_div.sv
// rtl/riscv_div.sv - iterative restoring divider for DIV/DIVU/REM/REMU (optional RISCV_DIV_EARLY_OUT_EN)
module riscv_div #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    riscv_div_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvsr;
    logic            is_rem_q, q_neg, r_neg, special;
    logic [XLEN-1:0] special_res;
    logic            accept, finish;

    // Request decode: magnitudes, sign flags and the two architecturally defined corner cases
    logic            in_signed, in_zero, in_ovf, in_special;
    logic [XLEN-1:0] abs_a, abs_b, in_special_res;

    always_comb begin
        in_signed  = ~bus.op_i[0];
        abs_a      = (in_signed && bus.dividend_i[XLEN-1]) ? -bus.dividend_i : bus.dividend_i;
        abs_b      = (in_signed && bus.divisor_i[XLEN-1])  ? -bus.divisor_i  : bus.divisor_i;
        in_zero    = (bus.divisor_i == '0);
        in_ovf     = in_signed && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == ONES);
        in_special = in_zero || in_ovf;
        if (in_zero)
            in_special_res = bus.op_i[1] ? bus.dividend_i : ONES;
        else
            in_special_res = bus.op_i[1] ? '0 : MIN_NEG;
    end

    // One restoring step; rem < dvsr always holds so the 33-bit trial sign is exact
    logic [XLEN:0]   rem_sh, trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix, calc_res;

    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        trial    = rem_sh - {1'b0, dvsr};
        trial_ok = ~trial[XLEN];
        rem_nx   = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx   = {quo[XLEN-2:0], trial_ok};
        quo_fix  = q_neg ? -quo_nx : quo_nx;
        rem_fix  = r_neg ? -rem_nx : rem_nx;
        if (special)
            calc_res = special_res;
        else
            calc_res = is_rem_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    accept = 1'b1;
`ifdef RISCV_DIV_EARLY_OUT_EN
                    state_nx = in_special ? S_DONE : S_CALC;
`else
                    state_nx = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_nx = S_IDLE;
                end else if (cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvsr        <= '0;
            is_rem_q    <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            special     <= 1'b0;
            special_res <= '0;
            bus.busy_o   <= 1'b0;
            bus.valid_o  <= 1'b0;
            bus.result_o <= '0;
        end else begin
            bus.busy_o  <= (state_nx != S_IDLE);
            bus.valid_o <= (state_nx == S_DONE);
            if (accept) begin
                cnt         <= CW'(XLEN - 1);
                quo         <= abs_a;
                rem         <= '0;
                dvsr        <= abs_b;
                is_rem_q    <= bus.op_i[1];
                q_neg       <= in_signed & (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
                r_neg       <= in_signed & bus.dividend_i[XLEN-1];
                special     <= in_special;
                special_res <= in_special_res;
`ifdef RISCV_DIV_EARLY_OUT_EN
                if (in_special)
                    bus.result_o <= in_special_res;
`endif
            end else if (state == S_CALC && !bus.flush_i) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt - 1'b1;
                if (finish)
                    bus.result_o <= calc_res;
            end
        end
    end
endmodule

// File: tb/tb_riscv_div.sv
// tb/tb_riscv_div.sv - self-checking bench for riscv_div (table, random and corner sequences)
module tb_riscv_div;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
    localparam int LAT_NORMAL = 32;
`ifdef RISCV_DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 0;
`else
    localparam int LAT_SPECIAL = 32;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    riscv_div_if #(.XLEN(32)) bus ();
    riscv_div #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic is_signed;
        is_signed = (op[0] == 1'b0);
        if (b == 0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (is_signed)
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0 || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    // Counts edges after the accepting edge until valid_o is seen; -1 on timeout
    task automatic wait_valid(output int lat, output logic [31:0] res);
        lat = -1;
        res = 32'h0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid_o) begin
                lat = k;
                res = bus.result_o;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] res;
        start_op(op, a, b);
        wait_valid(lat, res);
        check({name, " result"}, res, ref_div(op, a, b));
        check({name, " latency"}, 32'(lat), 32'(ref_lat(op, a, b)));
        check({name, " busy in done"}, {31'b0, bus.busy_o}, 32'd1);
        @(posedge clk);
        #1;
        check({name, " busy after"}, {31'b0, bus.busy_o}, 32'd0);
        check({name, " valid one cycle"}, {31'b0, bus.valid_o}, 32'd0);
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) n++;
        end
    endtask

    vec_t tbl[12];

    initial begin
        int lat, nv;
        logic [31:0] res, prev;
        logic [1:0]  op;
        logic [31:0] a, b;

        tbl[0]  = '{OP_DIVU, 32'd100, 32'd7, 32'd14};
        tbl[1]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        tbl[2]  = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        tbl[3]  = '{OP_REMU, 32'd7, 32'd2, 32'd1};
        tbl[4]  = '{OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tbl[5]  = '{OP_REM, 32'd5, 32'd0, 32'd5};
        tbl[6]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[7]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
        tbl[9]  = '{OP_REMU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        tbl[10] = '{OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tbl[11] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};

        bus.start_i = 1'b0; bus.op_i = 2'b00; bus.dividend_i = '0; bus.divisor_i = '0; bus.flush_i = 1'b0;
        #12;
        check("reset busy", {31'b0, bus.busy_o}, 32'd0);
        check("reset valid", {31'b0, bus.valid_o}, 32'd0);
        check("reset result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (ref_div(tbl[i].op, tbl[i].a, tbl[i].b) !== tbl[i].exp)
                $display("note: table row %0d expectation disagrees with model", i);
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_valid(lat, res);
            check($sformatf("tbl%0d result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d latency", i), 32'(lat), 32'(ref_lat(tbl[i].op, tbl[i].a, tbl[i].b)));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d busy after", i), {31'b0, bus.busy_o}, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rnd%0d op%0d %h/%h", i, op, a, b), op, a, b);
        end

        // Flush mid-calculation: no pulse, result retained, next op unaffected
        prev = bus.result_o;
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        check("flush busy", {31'b0, bus.busy_o}, 32'd0);
        check("flush result kept", bus.result_o, prev);
        count_valids(40, nv);
        check("flush no valid", 32'(nv), 32'd0);
        run_op("after flush 9/3", OP_DIVU, 32'd9, 32'd3);

        // Flush and start together in IDLE: start is not accepted
        @(negedge clk);
        bus.start_i = 1'b1; bus.flush_i = 1'b1;
        bus.op_i = OP_DIVU; bus.dividend_i = 32'd8; bus.divisor_i = 32'd2;
        @(posedge clk);
        #1 begin bus.start_i = 1'b0; bus.flush_i = 1'b0; end
        check("flush+start busy", {31'b0, bus.busy_o}, 32'd0);

        // Second start while busy is dropped; operand changes ignored
        start_op(OP_DIVU, 32'd50, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b1; bus.dividend_i = 32'd99; bus.divisor_i = 32'd2;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        wait_valid(lat, res);
        check("busy-start result", res, 32'd10);
        check("busy-start latency", 32'(lat + 5), 32'd32);
        count_valids(40, nv);
        check("busy-start dropped", 32'(nv), 32'd0);

        // Asynchronous reset mid-operation
        start_op(OP_DIV, 32'd1234, 32'd5);
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'b0, bus.busy_o}, 32'd0);
        check("async rst valid", {31'b0, bus.valid_o}, 32'd0);
        check("async rst result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset 20/4", OP_DIV, 32'd20, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
